rx_event_fifo: RTL



---
 rtl/rx_event_pkg.sv | 16 +
 rtl/rx_event_fifo_if.sv | 19 +
 rtl/rx_event_fifo_sync_fifo.sv | 61 ++++++
 rtl/rx_event_fifo.sv | 80 ++++++++
 4 files changed

// File: rtl/rx_event_pkg.sv
// Shared constants for the receive status word: bit offsets above the payload byte.
package rx_event_pkg;

  localparam int unsigned RX_BIT_PRESENT  = 0;
  localparam int unsigned RX_BIT_COMPLETE = 1;
  localparam int unsigned RX_BIT_VALID    = 2;
  localparam int unsigned RX_BIT_ABORT    = 3;
  localparam int unsigned RX_BIT_OVF      = 4;
  localparam int unsigned RX_FLAG_W       = 5;
  localparam int unsigned RX_RSVD_W       = 3;

  function automatic int unsigned rx_word_w(input int unsigned data_w);
    return data_w + RX_FLAG_W + RX_RSVD_W;
  endfunction

endpackage

// File: rtl/rx_event_fifo_if.sv
// Host-side status handshake: head word with strobe/accept plus occupancy.
interface rx_event_fifo_if
  import rx_event_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned WORD_W  = rx_word_w(DATA_W);
  localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0]  rx_data;
  logic               rx_strobe;
  logic               rx_accept;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (output rx_data, output rx_strobe, output fifo_level, input rx_accept);
  modport slave  (input rx_data, input rx_strobe, input fifo_level, output rx_accept);

endinterface

// File: rtl/rx_event_fifo_sync_fifo.sv
// Register-array FIFO with a registered head word; full/empty come from the level count.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         push_ok_c,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [LEVEL_W-1:0] level_next;
  logic               full;
  logic               empty;
  logic               pop_ok;
  logic               fwd;

  always_comb begin
    full        = (level == LEVEL_W'(DEPTH));
    empty       = (level == '0);
    pop_ok      = pop && !empty;
    push_ok_c   = push && (!full || pop_ok);
    level_next  = level + LEVEL_W'(push_ok_c) - LEVEL_W'(pop_ok);
    rd_ptr_next = rd_ptr + PTR_W'(pop_ok);
    // The new head is the word being written when nothing else remains after the pop.
    fwd         = push_ok_c && (level == LEVEL_W'(pop_ok));
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      valid   <= 1'b0;
      rd_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_ok_c);
      rd_ptr <= rd_ptr_next;
      level  <= level_next;
      valid  <= (level_next != '0);
      // Head holds its last value once the FIFO drains.
      if (level_next != '0) rd_data <= fwd ? push_data : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/rx_event_fifo.sv
// Synchronises deframer event levels, edge-detects them, packs status words and queues them for the host.
module rx_event_fifo
  import rx_event_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_ready,
  input  logic              frame_complete,
  input  logic              frame_valid,
  input  logic              abort,
  input  logic [DATA_W-1:0] dout,
  rx_event_fifo_if.master   host
);
  localparam int unsigned WORD_W = rx_word_w(DATA_W);
  localparam int unsigned B      = DATA_W;

  logic [3:0]        async_in;
  logic [3:0]        sync_q [SYNC_STAGES];
  logic [3:0]        sync_last;
  logic [2:0]        hist;
  logic [2:0]        evt;
  logic              push;
  logic              push_ok;
  logic              overflow_pending;
  logic [WORD_W-1:0] word;

  // Bit order: 0 byte_ready, 1 frame_complete, 2 abort, 3 frame_valid.
  assign async_in  = {frame_valid, abort, frame_complete, byte_ready};
  assign sync_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist <= sync_last[2:0];
    end
  end

  always_comb begin
    evt  = sync_last[2:0] & ~hist;
    push = |evt;
    word = '0;
    if (evt[0]) word[DATA_W-1:0] = dout;
    word[B + RX_BIT_PRESENT]  = evt[0];
    word[B + RX_BIT_COMPLETE] = evt[1];
    word[B + RX_BIT_VALID]    = evt[1] & sync_last[3];
    word[B + RX_BIT_ABORT]    = evt[2];
    word[B + RX_BIT_OVF]      = overflow_pending;
  end

  // Remembers dropped words so the next accepted word can flag the gap.
  always_ff @(posedge clk) begin
    if (reset)                overflow_pending <= 1'b0;
    else if (push && !push_ok) overflow_pending <= 1'b1;
    else if (push_ok)          overflow_pending <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (word),
    .pop       (host.rx_accept),
    .push_ok_c (push_ok),
    .rd_data   (host.rx_data),
    .valid     (host.rx_strobe),
    .level     (host.fifo_level)
  );

endmodule
